mem_bus_master: RTL and testbench
=================================

Name: mem_bus_master

Overview:
Initiator for the shared single-port memory bus. That bus has an address, active-high rd and wr strobes, and a bidirectional data bus. The memory writes on the clock edge while wr=1 and drives data combinationally while rd=1. This block converts single-word read/write requests from the core (valid/ready) into correctly sequenced bus cycles. It owns the tri-state data driver, captures read data, and returns a response through a held valid/ready channel.

Parameters:
ADDR_WIDTH, 5, memory address width
DATA_WIDTH, 8, memory data width

Ports:
clk  input  1  single clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
req_valid  input  1  core request present
req_ready  output  1  block can accept a request (IDLE only)
req_we  input  1  1=write, 0=read
req_addr  input  ADDR_WIDTH  request address
req_wdata  input  DATA_WIDTH  write data
rsp_valid  output  1  response available, held until rsp_ready
rsp_ready  input  1  core accepts response
rsp_we  output  1  echo of request type
rsp_data  output  DATA_WIDTH  read data (write: last captured value unchanged)
busy  output  1  high in any state other than IDLE
mem_addr  output  ADDR_WIDTH  bus address
mem_rd  output  1  read strobe
mem_wr  output  1  write strobe
mem_data  inout  DATA_WIDTH  bus data; driven only during write states, else high-Z

Behaviour:
- Reset state (async, on rst=1):
  - FSM=IDLE; req_ready=1, rsp_valid=0, rsp_we=0, rsp_data=0, busy=0.
  - mem_addr=0, mem_rd=0, mem_wr=0, mem_data=Z.
  - Strobes and driver are registered/decoded so they fall immediately on rst, mid-transaction included. An in-flight request is dropped and produces no response.
- States: IDLE, ADDR, RSTB, WSETUP, WSTB, WHOLD, RESP.
- IDLE:
  - req_ready=1; accept on req_valid&req_ready at a rising edge.
  - On accept, latch addr/we/wdata into internal registers, then go to ADDR (read) or WSETUP (write).
- Read path:
  - ADDR: mem_addr=latched addr, mem_rd=0, bus Z.
  - RSTB: mem_rd=1. rsp_data captures mem_data at the closing edge. Go to RESP.
  - Read latency: accept edge +2 edges until rsp_valid=1.
- Write path:
  - WSETUP: mem_addr valid, mem_data driven with latched wdata, mem_wr=0.
  - WSTB: mem_wr=1, data still driven. The memory writes at the closing edge.
  - WHOLD: mem_wr=0, data still driven (hold time). Then go to RESP with the bus released.
  - Write latency: accept edge +3 edges until rsp_valid=1.
- RESP:
  - rsp_valid=1; rsp_we=latched we.
  - rsp_data is stable for the whole of RESP.
  - Leave to IDLE on rsp_valid&rsp_ready. Back-pressure of any length is legal and holds all outputs.
  - A new request is accepted only from IDLE, one cycle after the response handshake. The peak rate is therefore 1 read per 4 cycles and 1 write per 5 cycles.
- mem_addr holds its last value in IDLE and RESP; it changes only on entry to ADDR/WSETUP.
- Invariants, each checked every cycle:
  - mem_rd & mem_wr never both 1.
  - The data driver is never enabled while mem_rd=1.
  - The data driver is enabled exactly in WSETUP, WSTB and WHOLD.
  - mem_wr is high for exactly one cycle per write.
  - mem_rd is high for exactly one cycle per read.
- req_* inputs are ignored outside IDLE; changes there have no effect.
- Width rules: no arithmetic. Addresses wrap naturally; address 2**ADDR_WIDTH-1 is legal.

Optional Feature:
- Macro MEM_MASTER_TURNAROUND_EN.
- Defined:
  - An extra TURN state (all strobes 0, bus Z) is inserted between WHOLD and RESP. This guarantees at least 2 driver-off cycles before any subsequent mem_rd.
  - Write latency becomes +4 edges.
- Undefined: TURN does not exist; timing is exactly as in Behaviour.

Test Plan:
- Reset mid-write: assert rst during WSTB. Required: mem_wr=0 and mem_data=Z in the same cycle (before the next edge), rsp_valid stays 0, and after release req_ready=1.
- Write 0xA5 to addr 3, then read addr 3. Required:
  - mem_wr high exactly 1 cycle, with mem_data=0xA5 across WSETUP..WHOLD.
  - Write rsp_valid 3 edges after accept.
  - Read rsp_valid 2 edges after accept, with rsp_data=0xA5 and rsp_we=0.
- Boundary address: write 0x3C to addr 31, then read addr 0 and addr 31. Required: addr 31 returns 0x3C and addr 0 is unaffected.
- Back-pressure: hold rsp_ready=0 for 10 cycles after a read. Required:
  - rsp_valid and rsp_data stable, req_ready=0, mem_rd=0.
  - A req_valid presented during the stall is not accepted until the cycle after the handshake.
- Protocol monitor over 200 random reads/writes (random req_valid/rsp_ready gaps). Required:
  - No rd/wr overlap and no driver-on during rd.
  - The scoreboard matches all read data against a reference memory model.
- With MEM_MASTER_TURNAROUND_EN: write then immediate read. Required: write latency is 4 edges, and at least 2 Z cycles separate driver-off from mem_rd=1.

Source files
------------

// File: rtl/mem_bus_master.sv
// mem_bus_master: single-word request/response front end for the shared
// single-port memory bus. Sequences address, strobe and data-hold phases,
// owns the tri-state data driver and captures read data.
// Optional macro MEM_MASTER_TURNAROUND_EN adds a bus turnaround state after
// each write so the driver is off for at least two cycles before a read.
module mem_bus_master #(
  parameter int unsigned ADDR_WIDTH = 5,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_we,
  output logic [DATA_WIDTH-1:0] rsp_data,
  output logic                  busy,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic                  mem_rd,
  output logic                  mem_wr,
  inout  wire  [DATA_WIDTH-1:0] mem_data
);

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StRstb,
    StWsetup,
    StWstb,
    StWhold,
`ifdef MEM_MASTER_TURNAROUND_EN
    StTurn,
`endif
    StResp
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic                  we_q, we_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rsp_data_q, rsp_data_d;
  logic                  drive_en;

  // State and request/response registers; reset drops any in-flight request.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      addr_q     <= '0;
      we_q       <= 1'b0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
    end
  end

  // Next-state logic: request latch on accept, read capture at end of strobe.
  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    we_d       = we_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          addr_d  = req_addr;
          we_d    = req_we;
          wdata_d = req_wdata;
          state_d = req_we ? StWsetup : StAddr;
        end
      end
      StAddr:   state_d = StRstb;
      StRstb: begin
        rsp_data_d = mem_data;
        state_d    = StResp;
      end
      StWsetup: state_d = StWstb;
      StWstb:   state_d = StWhold;
`ifdef MEM_MASTER_TURNAROUND_EN
      StWhold:  state_d = StTurn;
      StTurn:   state_d = StResp;
`else
      StWhold:  state_d = StResp;
`endif
      StResp: begin
        if (rsp_ready) state_d = StIdle;
      end
      default:  state_d = StIdle;
    endcase
  end

  // Outputs decoded from the state register so strobes drop with async reset.
  always_comb begin
    req_ready = (state_q == StIdle);
    busy      = (state_q != StIdle);
    rsp_valid = (state_q == StResp);
    mem_rd    = (state_q == StRstb);
    mem_wr    = (state_q == StWstb);
    drive_en  = (state_q == StWsetup) || (state_q == StWstb) || (state_q == StWhold);
  end

  assign mem_addr = addr_q;
  assign rsp_we   = we_q;
  assign rsp_data = rsp_data_q;
  assign mem_data = drive_en ? wdata_q : {DATA_WIDTH{1'bz}};

endmodule

// File: tb/tb_mem_bus_master.sv
// Self-checking bench for mem_bus_master: bus-side memory, transaction-level
// reference model with per-cycle timeline expectations, directed and random
// traffic. Undriven bus bits are pulled up, so "released" reads as 8'hFF.
module tb_mem_bus_master;

`ifdef MEM_MASTER_TURNAROUND_EN
  localparam int WLAT = 4;
`else
  localparam int WLAT = 3;
`endif

  logic       clk = 1'b0;
  logic       rst;
  logic       req_valid, req_we, rsp_ready;
  logic [4:0] req_addr;
  logic [7:0] req_wdata;
  logic       req_ready, rsp_valid, rsp_we, busy, mem_rd, mem_wr;
  logic [4:0] mem_addr;
  logic [7:0] rsp_data;
  wire  [7:0] mem_data;

  mem_bus_master #(.ADDR_WIDTH(5), .DATA_WIDTH(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_wdata (req_wdata),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_we    (rsp_we),
    .rsp_data  (rsp_data),
    .busy      (busy),
    .mem_addr  (mem_addr),
    .mem_rd    (mem_rd),
    .mem_wr    (mem_wr),
    .mem_data  (mem_data)
  );

  always #5 clk = ~clk;

  // Bus-side memory: writes on the edge while mem_wr, drives while mem_rd.
  logic [7:0] bus_mem [32];
  logic       mem_init;
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 32; i++) bus_mem[i] <= 8'h55 ^ 8'(i);
    end else if (mem_wr) begin
      bus_mem[mem_addr] <= mem_data;
    end
  end
  assign mem_data = mem_rd ? bus_mem[mem_addr] : 8'bz;

  for (genvar b = 0; b < 8; b++) begin : g_pu
    pullup pu (mem_data[b]);
  end

  // Reference model state.
  logic [7:0] ref_mem [32];
  bit         in_txn;
  int         n;
  bit         m_we;
  logic [4:0] m_addr, last_addr;
  logic [7:0] m_wdata, m_rdata, last_rd;
  int         gap, wr_seen, rd_seen;
  int         n_chk, n_pass;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  function automatic int lat_of();
    return m_we ? WLAT : 2;
  endfunction

  // Per-cycle comparison of every output against the model's timeline.
  task automatic compare();
    bit         exp_valid, exp_rd, exp_wr, exp_drv;
    logic [7:0] exp_bus;
    exp_valid = in_txn && (n >= lat_of() + 1);
    exp_rd    = in_txn && !m_we && (n == 2);
    exp_wr    = in_txn && m_we && (n == 2);
    exp_drv   = in_txn && m_we && (n >= 1) && (n <= 3);
    exp_bus   = exp_drv ? m_wdata : (exp_rd ? m_rdata : 8'hFF);
    chk("req_ready", req_ready, !in_txn);
    chk("busy", busy, in_txn);
    chk("rsp_valid", rsp_valid, exp_valid);
    chk("mem_addr", mem_addr, last_addr);
    chk("mem_rd", mem_rd, exp_rd);
    chk("mem_wr", mem_wr, exp_wr);
    chk("mem_data", mem_data, exp_bus);
    chk("rsp_data", rsp_data, last_rd);
    chk("rd_wr_overlap", mem_rd & mem_wr, 1'b0);
    if (exp_valid) chk("rsp_we", rsp_we, m_we);
    if (mem_rd) chk("turn_gap", gap >= 2, 1'b1);
    if (mem_data !== 8'hFF && !mem_rd) gap = 0;
    else gap++;
    if (mem_wr) wr_seen++;
    if (mem_rd) rd_seen++;
  endtask

  // Advance one clock: predict accept/handshake, update model, then compare.
  task automatic tick();
    bit acc, hs;
    acc = !in_txn && req_valid;
    hs  = in_txn && (n >= lat_of() + 1) && rsp_ready;
    @(posedge clk);
    if (hs) in_txn = 0;
    if (acc) begin
      in_txn    = 1;
      n         = 0;
      m_we      = req_we;
      m_addr    = req_addr;
      m_wdata   = req_wdata;
      m_rdata   = ref_mem[req_addr];
      last_addr = req_addr;
    end
    if (in_txn) n++;
    if (in_txn && n == 3) begin
      if (m_we) ref_mem[m_addr] = m_wdata;
      else last_rd = m_rdata;
    end
    @(negedge clk);
    compare();
  endtask

  task automatic start_req(input bit we, input logic [4:0] a, input logic [7:0] d);
    int k;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = a;
    req_wdata = d;
    k = 0;
    do begin
      tick();
      k++;
    end while (!(in_txn && n == 1) && k < 50);
    if (!(in_txn && n == 1)) chk("accept_timeout", 1'b0, 1'b1);
    req_valid = 1'b0;
    req_we    = 1'($urandom);
    req_addr  = 5'($urandom);
    req_wdata = 8'($urandom);
  endtask

  task automatic finish_req(input int stall, output int lat);
    lat = 0;
    while (rsp_valid !== 1'b1 && lat < 20) begin
      tick();
      lat++;
    end
    if (lat >= 20) chk("rsp_timeout", 1'b0, 1'b1);
    repeat (stall) tick();
    rsp_ready = 1'b1;
    tick();
    rsp_ready = 1'b0;
  endtask

  task automatic txn(input bit we, input logic [4:0] a, input logic [7:0] d,
                     input int stall, output int lat);
    start_req(we, a, d);
    finish_req(stall, lat);
  endtask

  initial begin
    int l, w0, r0;
    n_chk = 0; n_pass = 0; gap = 100; wr_seen = 0; rd_seen = 0;
    in_txn = 0; n = 0; m_we = 0; m_addr = '0; m_wdata = '0; m_rdata = '0;
    last_addr = '0; last_rd = '0;
    for (int i = 0; i < 32; i++) ref_mem[i] = 8'h55 ^ 8'(i);
    rst = 1'b1; mem_init = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    compare();
    chk("reset_rsp_we", rsp_we, 1'b0);
    chk("reset_rsp_data", rsp_data, 8'h00);
    rst = 1'b0; mem_init = 1'b0;
    repeat (2) tick();

    // Write 0xA5 to 3, read it back.
    w0 = wr_seen;
    txn(1'b1, 5'd3, 8'hA5, 0, l);
    chk("wr_latency", l, WLAT);
    chk("wr_pulse", wr_seen - w0, 1);
    r0 = rd_seen;
    txn(1'b0, 5'd3, 8'h00, 0, l);
    chk("rd_latency", l, 2);
    chk("rd_pulse", rd_seen - r0, 1);
    chk("rd_a5", rsp_data, 8'hA5);

    // Boundary address.
    txn(1'b1, 5'd31, 8'h3C, 1, l);
    txn(1'b0, 5'd0, 8'h00, 0, l);
    chk("rd_addr0", rsp_data, 8'h55);
    txn(1'b0, 5'd31, 8'h00, 2, l);
    chk("rd_addr31", rsp_data, 8'h3C);

    // Back-pressure with a competing request held during the stall.
    start_req(1'b0, 5'd3, 8'h00);
    req_valid = 1'b1; req_we = 1'b1; req_addr = 5'd9; req_wdata = 8'h77;
    finish_req(10, l);
    chk("bp_ready_after_hs", req_ready, 1'b1);
    chk("bp_data", rsp_data, 8'hA5);
    tick();
    chk("bp_accept_next", busy, 1'b1);
    req_valid = 1'b0;
    finish_req(0, l);
    txn(1'b0, 5'd9, 8'h00, 0, l);
    chk("bp_wr_landed", rsp_data, 8'h77);

    // Reset in the middle of a write strobe.
    start_req(1'b1, 5'd7, 8'h99);
    tick();
    rst = 1'b1;
    #1;
    chk("rst_mem_wr", mem_wr, 1'b0);
    chk("rst_mem_data", mem_data, 8'hFF);
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_req_ready", req_ready, 1'b1);
    in_txn = 0; last_addr = '0; last_rd = '0;
    @(posedge clk);
    @(negedge clk);
    compare();
    rst = 1'b0;
    tick();
    txn(1'b0, 5'd7, 8'h00, 0, l);
    chk("rst_no_write", rsp_data, 8'h52);

    // Immediate write-then-read turnaround.
    txn(1'b1, 5'd5, 8'h0F, 0, l);
    chk("turn_wr_latency", l, WLAT);
    txn(1'b0, 5'd5, 8'h00, 0, l);
    chk("turn_rd", rsp_data, 8'h0F);

    // Random traffic.
    for (int t = 0; t < 200; t++) begin
      repeat ($urandom_range(0, 3)) tick();
      txn(1'($urandom), 5'($urandom), 8'($urandom), int'($urandom_range(0, 3)), l);
    end
    repeat (3) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
